// File: rtl/cpu_alu_pkg.sv
// Purpose: opcode, state and helper definitions shared by the byte-serial ALU sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_ADC  = 4'b0001,
        ALU_SUB  = 4'b0010,
        ALU_SBC  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_ANDN = 4'b0111,
        ALU_SHL  = 4'b1000,
        ALU_SHR  = 4'b1001,
        ALU_ASL  = 4'b1010,
        ALU_ASR  = 4'b1011
    } alu_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_EXEC = 2'd1,
        SEQ_RESP = 2'd2
    } seq_state_e;

    // Opcode classes are decided by the top two bits.
    function automatic logic is_arith(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

    function automatic logic is_logic(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_byte_sequencer.sv
// Purpose: runs NUM_BYTES-wide ops on the shared 8-bit ALU one byte per cycle; owns C/Z flags.
// Latency: accept at T -> rsp_valid_o at T+NUM_BYTES+1 (shift/illegal: T+2).
// Backpressure: single-entry; cmd_ready_o only in IDLE, response held until rsp_ready_i.
module alu_byte_sequencer
    import cpu_alu_pkg::*;
#(
    parameter  int NUM_BYTES = 2,
    localparam int W         = 8 * NUM_BYTES
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [3:0]   cmd_op_i,
    input  logic [W-1:0] cmd_a_i,
    input  logic [W-1:0] cmd_b_i,
    input  logic [2:0]   cmd_count_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [W-1:0] rsp_res_o,
    output logic         rsp_err_o,
    output logic         flag_c_o,
    output logic         flag_z_o,
    output logic [7:0]   alu_rs_o,
    output logic [7:0]   alu_op2_o,
    output logic [2:0]   alu_count_o,
    output logic         alu_carry_o,
    output logic [3:0]   alu_op_o,
    input  logic [7:0]   alu_res_i,
    input  logic         alu_carry_i,
    input  logic         alu_zero_i
);

    // One spare bit so the index can represent NUM_BYTES without aliasing.
    localparam int IDXW = $clog2(NUM_BYTES) + 1;

    seq_state_e      state_q, state_d;
    logic [3:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [2:0]      count_q;
    logic [IDXW-1:0] idx_q;
    logic            zacc_q;
    logic            cbuf_q;
    logic [W-1:0]    res_q;
    logic            err_q;
    logic            flag_c_q;
    logic            flag_z_q;

    logic [7:0]      rs_byte;
    logic [7:0]      op2_byte;
    logic            first_byte;
    logic            last_byte;

    assign cmd_ready_o = (state_q == SEQ_IDLE);
    assign rsp_valid_o = (state_q == SEQ_RESP);
    assign rsp_res_o   = res_q;
    assign rsp_err_o   = err_q;
    assign flag_c_o    = flag_c_q;
    assign flag_z_o    = flag_z_q;

    assign first_byte = (idx_q == '0);
    // Shifts only ever touch the low byte.
    assign last_byte  = is_shift(op_q) || (idx_q == IDXW'(NUM_BYTES - 1));

    // Select the current operand bytes from the latched operands.
    always_comb begin
        rs_byte  = '0;
        op2_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IDXW'(i)) begin
                rs_byte  = a_q[8*i +: 8];
                op2_byte = b_q[8*i +: 8];
            end
        end
    end

    // Next-state logic and ALU drive; ALU inputs are quiet outside EXEC.
    always_comb begin
        state_d     = state_q;
        alu_rs_o    = '0;
        alu_op2_o   = '0;
        alu_count_o = '0;
        alu_carry_o = 1'b0;
        alu_op_o    = '0;
        case (state_q)
            SEQ_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (is_illegal(op_q)) begin
                    // One idle bubble keeps illegal-op latency equal to a shift.
                    state_d = SEQ_RESP;
                end else begin
                    alu_rs_o  = rs_byte;
                    alu_op2_o = op2_byte;
                    if (is_arith(op_q)) begin
                        // Upper bytes always use the carry-in form of the op.
                        alu_op_o    = {2'b00, op_q[1], op_q[0] | ~first_byte};
                        alu_carry_o = first_byte ? (op_q[0] & flag_c_q) : cbuf_q;
                    end else begin
                        alu_op_o = op_q;
                        if (is_shift(op_q)) begin
                            alu_count_o = count_q;
                        end
                    end
                    if (last_byte) begin
                        state_d = SEQ_RESP;
                    end
                end
            end
            SEQ_RESP: begin
                if (rsp_ready_i) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch, per-byte result capture and architectural flag update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            zacc_q   <= 1'b0;
            cbuf_q   <= 1'b0;
            res_q    <= '0;
            err_q    <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q    <= cmd_op_i;
                        a_q     <= cmd_a_i;
                        b_q     <= cmd_b_i;
                        count_q <= cmd_count_i;
                        idx_q   <= '0;
                        zacc_q  <= 1'b1;
                        cbuf_q  <= 1'b0;
                        res_q   <= '0;
                        err_q   <= is_illegal(cmd_op_i);
                    end
                end
                SEQ_EXEC: begin
                    if (!is_illegal(op_q)) begin
                        for (int i = 0; i < NUM_BYTES; i++) begin
                            if (idx_q == IDXW'(i)) begin
                                res_q[8*i +: 8] <= alu_res_i;
                            end
                        end
                        zacc_q <= zacc_q & alu_zero_i;
                        cbuf_q <= alu_carry_i;
                        if (last_byte) begin
                            flag_z_q <= zacc_q & alu_zero_i;
                            if (!is_logic(op_q)) begin
                                flag_c_q <= alu_carry_i;
                            end
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_byte_sequencer.sv
module tb_alu_byte_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [3:0]  cmd_op_i;
    logic [15:0] cmd_a_i;
    logic [15:0] cmd_b_i;
    logic [2:0]  cmd_count_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_res_o;
    logic        rsp_err_o;
    logic        flag_c_o;
    logic        flag_z_o;
    logic [7:0]  alu_rs_o;
    logic [7:0]  alu_op2_o;
    logic [2:0]  alu_count_o;
    logic        alu_carry_o;
    logic [3:0]  alu_op_o;
    logic [7:0]  alu_res_i;
    logic        alu_carry_i;
    logic        alu_zero_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    alu_byte_sequencer #(.NUM_BYTES(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_a_i     (cmd_a_i),
        .cmd_b_i     (cmd_b_i),
        .cmd_count_i (cmd_count_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_res_o   (rsp_res_o),
        .rsp_err_o   (rsp_err_o),
        .flag_c_o    (flag_c_o),
        .flag_z_o    (flag_z_o),
        .alu_rs_o    (alu_rs_o),
        .alu_op2_o   (alu_op2_o),
        .alu_count_o (alu_count_o),
        .alu_carry_o (alu_carry_o),
        .alu_op_o    (alu_op_o),
        .alu_res_i   (alu_res_i),
        .alu_carry_i (alu_carry_i),
        .alu_zero_i  (alu_zero_i)
    );

    // Behavioural 8-bit combinational ALU standing in for the real one.
    logic [8:0] alu_t;
    logic       alu_cin;
    always_comb begin
        alu_t   = '0;
        alu_cin = alu_op_o[0] & alu_carry_o;
        case (alu_op_o)
            4'h0, 4'h1: alu_t = {1'b0, alu_rs_o} + {1'b0, alu_op2_o} + {8'h0, alu_cin};
            4'h2, 4'h3: alu_t = {1'b0, alu_rs_o} - {1'b0, alu_op2_o} - {8'h0, alu_cin};
            4'h4:       alu_t = {1'b0, alu_rs_o & alu_op2_o};
            4'h5:       alu_t = {1'b0, alu_rs_o | alu_op2_o};
            4'h6:       alu_t = {1'b0, alu_rs_o ^ alu_op2_o};
            4'h7:       alu_t = {1'b0, alu_rs_o & ~alu_op2_o};
            4'h8, 4'hA: alu_t = {1'b0, alu_rs_o} << alu_count_o;
            4'h9: begin
                alu_t = {alu_rs_o, 1'b0} >> alu_count_o;
                alu_t = {alu_t[0], alu_t[8:1]};
            end
            4'hB: begin
                alu_t = $signed({alu_rs_o, 1'b0}) >>> alu_count_o;
                alu_t = {alu_t[0], alu_t[8:1]};
            end
            default: alu_t = '0;
        endcase
    end
    assign alu_res_i   = alu_t[7:0];
    assign alu_carry_i = alu_t[8];
    assign alu_zero_i  = (alu_t[7:0] == 8'h00);

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  cnt;
        logic [15:0] res;
        logic        err;
        logic        c;
        logic        z;
        int          lat;
        logic [3:0]  op0;
        logic [3:0]  op1;
        logic        ci0;
        logic        ci1;
        logic [2:0]  ecnt;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        err;
        logic        c;
        logic        z;
    } exp_t;

    vec_t tbl[16];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, " rsp_res"},   32'(rsp_res_o),   32'd0);
        chk({tag, " rsp_err"},   32'(rsp_err_o),   32'd0);
        chk({tag, " flag_c"},    32'(flag_c_o),    32'd0);
        chk({tag, " flag_z"},    32'(flag_z_o),    32'd0);
        chk({tag, " alu_bus"},   {6'd0, alu_rs_o, alu_op2_o, alu_count_o, alu_carry_o, alu_op_o}, 32'd0);
    endtask

    // Issue one command, trace the ALU bus while EXEC runs, then drain the response.
    task automatic run_vec(input vec_t v, input int id);
        logic [3:0] op_seen[8];
        logic       ci_seen[8];
        logic [7:0] rs_seen[8];
        logic [7:0] op2_seen[8];
        logic [2:0] cnt_seen[8];
        int         lat;
        int         n;
        exp_t       e;
        string      tag;
        tag = $sformatf("vec%0d", id);
        @(negedge clk_i);
        chk({tag, " ready_idle"}, 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_op_i    = v.op;
        cmd_a_i     = v.a;
        cmd_b_i     = v.b;
        cmd_count_i = v.cnt;
        sb.push_back('{v.res, v.err, v.c, v.z});
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_a_i     = 16'($urandom);
        cmd_b_i     = 16'($urandom);
        cmd_op_i    = 4'($urandom);
        lat = 1;
        n   = 0;
        while (!rsp_valid_o && lat < 8) begin
            op_seen[n]  = alu_op_o;
            ci_seen[n]  = alu_carry_o;
            rs_seen[n]  = alu_rs_o;
            op2_seen[n] = alu_op2_o;
            cnt_seen[n] = alu_count_o;
            n++;
            @(negedge clk_i);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        if (n >= 1) begin
            chk({tag, " op_b0"},  32'(op_seen[0]),  32'(v.op0));
            chk({tag, " cin_b0"}, 32'(ci_seen[0]),  32'(v.ci0));
            chk({tag, " cnt_b0"}, 32'(cnt_seen[0]), 32'(v.ecnt));
            chk({tag, " rs_b0"},  32'(rs_seen[0]),  v.err ? 32'd0 : 32'(v.a[7:0]));
            chk({tag, " op2_b0"}, 32'(op2_seen[0]), v.err ? 32'd0 : 32'(v.b[7:0]));
        end
        if (v.lat == 3 && n >= 2) begin
            chk({tag, " op_b1"},  32'(op_seen[1]),  32'(v.op1));
            chk({tag, " cin_b1"}, 32'(ci_seen[1]),  32'(v.ci1));
            chk({tag, " rs_b1"},  32'(rs_seen[1]),  32'(v.a[15:8]));
            chk({tag, " op2_b1"}, 32'(op2_seen[1]), 32'(v.b[15:8]));
        end
        e = sb.pop_front();
        for (int h = 0; h < v.hold; h++) begin
            chk({tag, " hold_valid"}, 32'(rsp_valid_o), 32'd1);
            chk({tag, " hold_ready"}, 32'(cmd_ready_o), 32'd0);
            chk({tag, " hold_res"},   32'(rsp_res_o),   32'(e.res));
            chk({tag, " hold_err"},   32'(rsp_err_o),   32'(e.err));
            chk({tag, " hold_aluop"}, 32'(alu_op_o),    32'd0);
            @(negedge clk_i);
        end
        chk({tag, " res"},    32'(rsp_res_o), 32'(e.res));
        chk({tag, " err"},    32'(rsp_err_o), 32'(e.err));
        chk({tag, " flag_c"}, 32'(flag_c_o),  32'(e.c));
        chk({tag, " flag_z"}, 32'(flag_z_o),  32'(e.z));
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk({tag, " post_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, " post_ready"}, 32'(cmd_ready_o), 32'd1);
    endtask

    initial begin
        //             op    a        b        cnt  res      err c  z  lat op0  op1  ci0 ci1 ecnt hold
        tbl[0]  = '{4'h0, 16'h00FF, 16'h0001, 3'd0, 16'h0100, 0, 0, 0, 3, 4'h0, 4'h1, 0, 1, 3'd0, 0};
        tbl[1]  = '{4'h0, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 0, 1, 1, 3, 4'h0, 4'h1, 0, 1, 3'd0, 0};
        tbl[2]  = '{4'h6, 16'h5AA5, 16'h5AA5, 3'd0, 16'h0000, 0, 1, 1, 3, 4'h6, 4'h6, 0, 0, 3'd0, 0};
        tbl[3]  = '{4'h1, 16'h0000, 16'h0000, 3'd0, 16'h0001, 0, 0, 0, 3, 4'h1, 4'h1, 1, 0, 3'd0, 0};
        tbl[4]  = '{4'h2, 16'h0100, 16'h0001, 3'd0, 16'h00FF, 0, 0, 0, 3, 4'h2, 4'h3, 0, 1, 3'd0, 0};
        tbl[5]  = '{4'h2, 16'h0000, 16'h0001, 3'd0, 16'hFFFF, 0, 1, 0, 3, 4'h2, 4'h3, 0, 1, 3'd0, 0};
        tbl[6]  = '{4'h3, 16'h0005, 16'h0003, 3'd0, 16'h0001, 0, 0, 0, 3, 4'h3, 4'h3, 1, 0, 3'd0, 0};
        tbl[7]  = '{4'h4, 16'h0F0F, 16'h00FF, 3'd0, 16'h000F, 0, 0, 0, 3, 4'h4, 4'h4, 0, 0, 3'd0, 0};
        tbl[8]  = '{4'h5, 16'h1200, 16'h0034, 3'd0, 16'h1234, 0, 0, 0, 3, 4'h5, 4'h5, 0, 0, 3'd0, 0};
        tbl[9]  = '{4'h7, 16'hFFFF, 16'h0F0F, 3'd0, 16'hF0F0, 0, 0, 0, 3, 4'h7, 4'h7, 0, 0, 3'd0, 0};
        tbl[10] = '{4'h8, 16'h1281, 16'h0000, 3'd1, 16'h0002, 0, 1, 0, 2, 4'h8, 4'h0, 0, 0, 3'd1, 0};
        tbl[11] = '{4'h9, 16'h0001, 16'h0000, 3'd1, 16'h0000, 0, 1, 1, 2, 4'h9, 4'h0, 0, 0, 3'd1, 0};
        tbl[12] = '{4'hB, 16'h0080, 16'h0000, 3'd3, 16'h00F0, 0, 0, 0, 2, 4'hB, 4'h0, 0, 0, 3'd3, 0};
        tbl[13] = '{4'hA, 16'hFF40, 16'h0000, 3'd2, 16'h0000, 0, 1, 1, 2, 4'hA, 4'h0, 0, 0, 3'd2, 0};
        tbl[14] = '{4'hC, 16'h1234, 16'h5678, 3'd5, 16'h0000, 1, 1, 1, 2, 4'h0, 4'h0, 0, 0, 3'd0, 5};
        tbl[15] = '{4'h0, 16'h8000, 16'h8000, 3'd0, 16'h0000, 0, 1, 1, 3, 4'h0, 4'h1, 0, 0, 3'd0, 0};

        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = '0;
        cmd_a_i     = '0;
        cmd_b_i     = '0;
        cmd_count_i = '0;
        rsp_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk_reset_values("reset");
        rst_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_vec(tbl[i], i);
        end

        // Abort during the upper byte of an ADD; flags were C=1,Z=1 before.
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_op_i    = 4'h0;
        cmd_a_i     = 16'h12F0;
        cmd_b_i     = 16'h0001;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("abort op_b0", 32'(alu_op_o), 32'd0);
        @(negedge clk_i);
        chk("abort op_b1", 32'(alu_op_o), 32'd1);
        chk("abort cin_b1", 32'(alu_carry_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_reset_values("abort");
        rst_i = 1'b0;

        // Carry flag was cleared by reset, so ADC must not add one.
        run_vec('{4'h1, 16'h0001, 16'h0001, 3'd0, 16'h0002, 0, 0, 0, 3, 4'h1, 4'h1, 0, 0, 3'd0, 0}, 16);

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
